math_sub_96: RTL and testbench

- Pipelined 96-bit unsigned subtractor: dout = dina - dinb, producing a 97-bit two's-complement difference.
- Built as two 48-bit slices. The borrow is carried between slices through a pipeline register.
- Companion to the 96-bit cascaded adder, for differences of wide timestamps and accumulators in the datapath.
- Adds a valid qualifier and synchronous reset so downstream blocks can consume results without tracking latency externally.

---
 rtl/math_sub_96.sv | 116 +++++++++++
 tb/tb_math_sub_96.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/math_sub_96.sv
// -----------------------------------------------------------------------------
// math_sub_96
//   Pipelined 96-bit unsigned subtractor with a 97-bit two's-complement result:
//   dout = {1'b0,dina} - {1'b0,dinb}. dout[96] set means dina < dinb.
//   The subtraction is split into two 48-bit slices. The carry out of the low
//   slice is registered and consumed by the high slice one stage later. Fixed
//   3-cycle latency with a valid qualifier that travels alongside the data.
//
//   Optional build macro: MATH_SUB_96_SAT_EN
//     When defined, a negative result is clamped at the output register:
//     dout[95:0] is forced to 0 and dout[96]=1 remains as the underflow flag.
//
// Parameters
//   LATENCY    : pipeline depth, fixed at 3 (any other value fails elaboration)
//
// Ports
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   din_valid  : dina/dinb qualify this cycle
//   dina       : 96-bit unsigned minuend
//   dinb       : 96-bit unsigned subtrahend
//   dout_valid : dout qualifies this cycle
//   dout       : 97-bit two's-complement difference
// -----------------------------------------------------------------------------
module math_sub_96 #(
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din_valid,
  input  logic [95:0] dina,
  input  logic [95:0] dinb,
  output logic        dout_valid,
  output logic [96:0] dout
);

  if (LATENCY != 3) begin : g_latency_check
    $error("math_sub_96: LATENCY is fixed at 3");
  end

`ifdef MATH_SUB_96_SAT_EN
  // Unsigned floor at zero; the sign bit is kept as an underflow flag.
  function automatic logic [96:0] clamp_underflow(input logic [96:0] d);
    if (d[96]) return {1'b1, 96'd0};
    return d;
  endfunction
`endif

  logic [95:0] a_p0;
  logic [95:0] b_p0;
  logic        vld_p0;

  logic [48:0] lo_sum;
  logic [47:0] lo_p1;
  logic        c_lo_p1;
  logic [47:0] a_hi_p1;
  logic [47:0] b_hi_p1;
  logic        vld_p1;

  logic [48:0] hi_sum;
  logic [96:0] raw_diff;
  logic [96:0] res_diff;
  logic [96:0] dout_p2;
  logic        vld_p2;
  logic        live_p2;

  // ---- Stage 1: input capture ----
  always_ff @(posedge clk) begin
    a_p0 <= dina;
    b_p0 <= dinb;
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= din_valid;
  end

  // ---- Stage 2: low slice, a + ~b + 1 ----
  assign lo_sum = {1'b0, a_p0[47:0]} + {1'b0, ~b_p0[47:0]} + 49'd1;

  always_ff @(posedge clk) begin
    lo_p1   <= lo_sum[47:0];
    c_lo_p1 <= lo_sum[48];
    a_hi_p1 <= a_p0[95:48];
    b_hi_p1 <= b_p0[95:48];
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= vld_p0;
  end

  // ---- Stage 3: high slice with registered carry-in ----
  // No carry out of the high slice means a borrow, i.e. a negative result.
  assign hi_sum   = {1'b0, a_hi_p1} + {1'b0, ~b_hi_p1} + {48'd0, c_lo_p1};
  assign raw_diff = {~hi_sum[48], hi_sum[47:0], lo_p1};

`ifdef MATH_SUB_96_SAT_EN
  assign res_diff = clamp_underflow(raw_diff);
`else
  assign res_diff = raw_diff;
`endif

  // dout is held at zero after reset until the first valid result arrives, so
  // garbage flowing through the unreset data stages never becomes visible.
  // Once a valid result has been seen the data path updates every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      live_p2 <= 1'b0;
      dout_p2 <= '0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) live_p2 <= 1'b1;
      if (vld_p1 || live_p2) dout_p2 <= res_diff;
    end
  end

  assign dout_valid = vld_p2;
  assign dout       = dout_p2;

endmodule

// File: tb/tb_math_sub_96.sv
// -----------------------------------------------------------------------------
// tb_math_sub_96
//   Directed self-checking bench for math_sub_96: reset state, single-op
//   latency, cross-slice borrow, underflow, extremes, a back-to-back stream
//   with valid gaps and corners, and a reset in the middle of a stream.
// -----------------------------------------------------------------------------
module tb_math_sub_96;

  logic        clk;
  logic        rst;
  logic        din_valid;
  logic [95:0] dina;
  logic [95:0] dinb;
  logic        dout_valid;
  logic [96:0] dout;

  int n_checks;
  int n_pass;

  localparam logic [95:0] ONES96 = {96{1'b1}};

  math_sub_96 #(.LATENCY(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .dina       (dina),
    .dinb       (dinb),
    .dout_valid (dout_valid),
    .dout       (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [96:0] got, input logic [96:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [96:0] model(input logic [95:0] a, input logic [95:0] b);
    logic [96:0] d;
    d = {1'b0, a} - {1'b0, b};
`ifdef MATH_SUB_96_SAT_EN
    if (d[96]) d = {1'b1, 96'd0};
`endif
    return d;
  endfunction

  // One isolated operation: verify nothing before the third edge, the result
  // on the third edge, and valid dropping again on the fourth.
  task automatic run_one(input string tag, input logic [95:0] a, input logic [95:0] b,
                         input logic [96:0] exp);
    din_valid = 1'b1; dina = a; dinb = b;
    tick();
    din_valid = 1'b0; dina = $urandom; dinb = $urandom;
    tick();
    check({tag, "_early_vld"}, {96'd0, dout_valid}, 97'd0);
    tick();
    check({tag, "_vld"}, {96'd0, dout_valid}, 97'd1);
    check({tag, "_dout"}, dout, exp);
    tick();
    check({tag, "_vld_after"}, {96'd0, dout_valid}, 97'd0);
  endtask

  logic        s_vld [0:139];
  logic [96:0] s_exp [0:139];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1; din_valid = 1'b0; dina = '0; dinb = '0;

    // Reset state
    tick();
    tick();
    check("rst_vld", {96'd0, dout_valid}, 97'd0);
    check("rst_dout", dout, 97'd0);

    // Idle after release with junk operands: output must stay zero
    rst = 1'b0; dina = 96'h1234_5678_9ABC; dinb = 96'd5;
    tick(); tick(); tick();
    check("idle_vld", {96'd0, dout_valid}, 97'd0);
    check("idle_dout", dout, 97'd0);

    run_one("single", 96'd1000, 96'd1, 97'd999);
    run_one("xborrow", 96'h1_0000_0000_0000, 96'd1, 97'h0_FFFF_FFFF_FFFF);
`ifdef MATH_SUB_96_SAT_EN
    run_one("underflow", 96'd0, 96'd1, {1'b1, 96'd0});
`else
    run_one("underflow", 96'd0, 96'd1, 97'h1_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF);
`endif
    run_one("equal", ONES96, ONES96, 97'd0);
    run_one("max_minus_0", ONES96, 96'd0, {1'b0, ONES96});
    run_one("lo_borrow_hi", 96'h0000_0002_0000_0000_0000_0000, 96'h0000_0001_0000_0000_0000_0001,
            97'h0_0000_0000_FFFF_FFFF_FFFF_FFFF);

    // Rst wins over a simultaneous valid input
    rst = 1'b1; din_valid = 1'b1; dina = 96'd50; dinb = 96'd8;
    tick();
    rst = 1'b0; din_valid = 1'b0;
    tick(); tick(); tick();
    check("rst_wins_vld", {96'd0, dout_valid}, 97'd0);
    check("rst_wins_dout", dout, 97'd0);

    // Back-to-back stream with corners and gaps.
    // After tick i the output reflects the input driven in iteration i-2.
    for (int i = 0; i < 140; i++) begin
      logic [95:0] a, b;
      a = {$urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom};
      if (i % 10 == 3) begin a = ONES96; b = '0; end
      if (i % 10 == 4) begin a = '0; b = ONES96; end
      if (i % 10 == 5) b = a;
      if (i % 10 == 8) begin a = {48'd7, 48'd0}; b = {48'd3, 48'd1}; end
      s_vld[i] = (i < 130) && (i % 7 != 6);
      s_exp[i] = model(a, b);
      din_valid = s_vld[i]; dina = a; dinb = b;
      tick();
      if (i >= 2) begin
        check("stream_vld", {96'd0, dout_valid}, {96'd0, s_vld[i-2]});
        if (s_vld[i-2]) check("stream_dout", dout, s_exp[i-2]);
      end
    end

    // Reset mid-stream: valid continuously, rst for one cycle at c == 10
    for (int c = 0; c < 20; c++) begin
      logic [95:0] a, b;
      a = 96'(c * 1000 + 7);
      b = 96'(c * 3);
      if (c == 4) begin a = 96'd0; b = 96'd2; end
      s_exp[c] = model(a, b);
      rst = (c == 10);
      din_valid = 1'b1; dina = a; dinb = b;
      tick();
      if (c >= 10 && c <= 12) begin
        check("midrst_vld", {96'd0, dout_valid}, 97'd0);
        check("midrst_dout", dout, 97'd0);
      end else if (c >= 2) begin
        check("midrst_run_vld", {96'd0, dout_valid}, 97'd1);
        check("midrst_run_dout", dout, s_exp[c-2]);
      end
    end
    rst = 1'b0; din_valid = 1'b0;
    tick(); tick(); tick();
    check("final_vld", {96'd0, dout_valid}, 97'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
